// File: rtl/cnn_mul_arb_if.sv
// Request/result bundle for cnn_mul_arb: per-requester operands in, one product stream out.
interface cnn_mul_arb_if #(
  parameter int NREQ = 4,
  parameter int A_W  = 14,
  parameter int B_W  = 8,
  parameter int P_W  = A_W + B_W
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*A_W-1:0]     req_a;
  logic [NREQ*B_W-1:0]     req_b;
  logic                    res_valid;
  logic                    res_ready;
  logic [$clog2(NREQ)-1:0] res_id;
  logic signed [P_W-1:0]   res_p;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_p
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_p
  );
endinterface

// File: rtl/cnn_mul_arb.sv
// Round-robin arbiter sharing one signed multiplier among NREQ requesters.
// Define CNN_MUL_ARB_OUTREG_EN to add a registered output stage (latency +1).
module cnn_mul_arb #(
  parameter int NREQ = 4,
  parameter int A_W  = 14,
  parameter int B_W  = 8,
  parameter int P_W  = A_W + B_W
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  cnn_mul_arb_if.slave        bus,
  output logic [15:0]         op_count
);
  localparam int IDW = $clog2(NREQ);

  logic                  adv;
  logic                  any_valid;
  logic                  accept;
  logic                  res_valid;
  logic [IDW-1:0]        grant;
  logic [IDW-1:0]        idx;
  logic [NREQ-1:0]       ready;

  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [15:0]           op_count_q, op_count_d;

  logic                  s1_valid_q;
  logic [IDW-1:0]        s1_id_q;
  logic signed [A_W-1:0] s1_a_q;
  logic signed [B_W-1:0] s1_b_q;

  logic                  s2_valid_q;
  logic [IDW-1:0]        s2_id_q;
  logic signed [P_W-1:0] s2_p_q;
  logic signed [P_W-1:0] prod;

  // Scan starts one past the last winner so the previous grantee is checked last.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = rr_ptr_q + IDW'(k);
      if (!any_valid && bus.req_valid[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    adv    = !res_valid || bus.res_ready;
    accept = any_valid && adv && ap_rst_n;
    ready  = '0;
    if (accept) ready[grant] = 1'b1;
    rr_ptr_d   = accept ? grant : rr_ptr_q;
    op_count_d = accept ? op_count_q + 16'd1 : op_count_q;
  end

  assign bus.req_ready = ready;
  assign op_count      = op_count_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      rr_ptr_q   <= IDW'(NREQ - 1);
      op_count_q <= '0;
    end else if (adv) begin
      s1_valid_q <= accept;
      rr_ptr_q   <= rr_ptr_d;
      op_count_q <= op_count_d;
      if (accept) begin
        s1_id_q <= grant;
        s1_a_q  <= $signed(bus.req_a[int'(grant)*A_W +: A_W]);
        s1_b_q  <= $signed(bus.req_b[int'(grant)*B_W +: B_W]);
      end
    end
  end

  assign prod = P_W'(s1_a_q) * P_W'(s1_b_q);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_p_q     <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_id_q <= s1_id_q;
        s2_p_q  <= prod;
      end
    end
  end

`ifdef CNN_MUL_ARB_OUTREG_EN
  logic                  s3_valid_q;
  logic [IDW-1:0]        s3_id_q;
  logic signed [P_W-1:0] s3_p_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s3_valid_q <= 1'b0;
      s3_id_q    <= '0;
      s3_p_q     <= '0;
    end else if (adv) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_id_q <= s2_id_q;
        s3_p_q  <= s2_p_q;
      end
    end
  end

  assign res_valid  = s3_valid_q;
  assign bus.res_id = s3_id_q;
  assign bus.res_p  = s3_p_q;
`else
  assign res_valid  = s2_valid_q;
  assign bus.res_id = s2_id_q;
  assign bus.res_p  = s2_p_q;
`endif

  assign bus.res_valid = res_valid;
endmodule

// File: doc/cnn_mul_arb.md
CNN_MUL_ARB -- requirements
Module: cnn_mul_arb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters; fixed at 4 in this revision.
REQ-002 Parameter: A_W, 14, signed operand A width.
REQ-003 Parameter: B_W, 8, signed operand B width.
REQ-004 Parameter: P_W, 22, signed product width (A_W+B_W).
REQ-005 Port: ap_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port: ap_rst_n  in  1  synchronous, active-low reset.
REQ-007 Port: req_valid  in  4  per-requester operand-valid.
REQ-008 Port: req_ready  out  4  per-requester accept; at most one bit high per cycle.
REQ-009 Port: req_a  in  56  packed signed A operands; requester i at bits [14i+13:14i].
REQ-010 Port: req_b  in  32  packed signed B operands; requester i at bits [8i+7:8i].
REQ-011 Port: res_valid  out  1  product valid.
REQ-012 Port: res_ready  in  1  downstream accept.
REQ-013 Port: res_id  out  2  index of the requester that issued res_p.
REQ-014 Port: res_p  out  22  signed product A*B.
REQ-015 Port: op_count  out  16  count of accepted operations, wraps modulo 2^16.

Function
REQ-016 The block SHALL share one A_W x B_W signed multiplier among NREQ requesters via round-robin arbitration.
REQ-017 Pipeline advance: adv = !res_valid | res_ready; all pipeline registers SHALL hold when adv=0.
REQ-018 Grant: among set req_valid bits, SHALL select the first index after rr_ptr (mod 4); req_ready[g]=adv, all other bits 0; req_ready SHALL be 0 when no req_valid is set.
REQ-019 Accept: req_valid[i]&req_ready[i]; on accept SHALL capture a, b, id into stage-1 regs with s1_valid=1, set rr_ptr=i, and increment op_count.
REQ-020 Without accept while adv=1, s1_valid SHALL become 0; rr_ptr and op_count SHALL hold.
REQ-021 Stage 2 SHALL register the full-precision signed product of the stage-1 operands; no truncation or saturation; e.g. -8192 * -128 = 1048576.
REQ-022 Latency: an operation accepted at edge N SHALL appear with res_valid=1 after edge N+2 absent stalls.
REQ-023 res_valid, res_id and res_p SHALL stay stable while res_valid=1 and res_ready=0.
REQ-024 Full throughput: one accept per cycle while res_ready=1 and any req_valid is set.
REQ-025 Fairness: with all four requesters continuously valid, grants SHALL rotate 0,1,2,3,0...; no requester waits more than 3 accepts.
REQ-026 A requester deasserting req_valid before acceptance SHALL lose its grant with no side effects.
REQ-027 op_count SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-028 When ap_rst_n=0 at a rising edge: s1_valid=0, res_valid=0, res_id=0, res_p=0, op_count=0, rr_ptr=3 (requester 0 first).
REQ-029 req_ready SHALL be 0 in every cycle where ap_rst_n=0.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; no res_valid pulse for them after reset release.

Configuration
REQ-031 Macro CNN_MUL_ARB_OUTREG_EN defined: adds a third registered stage after the product; latency N+3; REQ-017/REQ-023 stall rules apply to all stages.
REQ-032 Macro undefined: two-stage pipeline; latency N+2.

Verification
REQ-033 Reset, then req_valid=0001, a0=100, b0=-3 -> req_ready=0001; two cycles later res_valid=1, res_id=0, res_p=-300; op_count=1.
REQ-034 req_valid=1111 held for 8 cycles, res_ready=1 -> grant order 0,1,2,3,0,1,2,3; op_count=8; results in same order.
REQ-035 a=-8192, b=-128 and a=8191, b=127 -> res_p=1048576 and 1040257.
REQ-036 res_ready=0 for 5 cycles with res_valid=1 -> res_p/res_id stable, req_ready=0000 while s1 occupied; no loss or duplication on release.
REQ-037 ap_rst_n=0 for one cycle while two operations in flight -> res_valid=0, op_count=0, next grant goes to requester 0.
REQ-038 Preload 65535 accepts (or force op_count) then one more -> op_count=0x0000.
